// File: rtl/reset_req_gen.sv
// Reset-request initiator: qualifies button, software and watchdog sources into a
// minimum-width active-low reset request and keeps a sticky record of the cause.
module reset_req_gen #(
    parameter int unsigned DEBOUNCE_CNT = 8,
    parameter int unsigned PULSE_LEN    = 16,
    parameter int unsigned HOLDOFF_LEN  = 8,
    parameter int unsigned WDT_LIMIT    = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_n,
    input  logic       sw_req,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    input  logic       cause_clr,
    output logic       rst_req_n,
    output logic       busy,
    output logic [2:0] cause
);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        HOLDOFF
    } state_t;

    localparam int unsigned MAXL = (PULSE_LEN > HOLDOFF_LEN) ? PULSE_LEN : HOLDOFF_LEN;
    localparam int unsigned CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
    localparam int unsigned DW   = $clog2(DEBOUNCE_CNT + 1);
    localparam int unsigned WW   = $clog2(WDT_LIMIT);

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_LEN - 1);
    localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CNT - 1);
    localparam logic [WW-1:0] WDT_LAST   = WW'(WDT_LIMIT - 1);

    state_t          state, next_state;
    logic [CW-1:0]   cnt, next_cnt;
    logic            btn_s1, btn_s;
    logic [DW-1:0]   deb_cnt;
    logic [WW-1:0]   wdt_cnt;
    logic            is_idle;
    logic            btn_evt, sw_evt, wdt_evt;
    logic [2:0]      evts;

    assign is_idle = (state == IDLE);
    assign btn_evt = !btn_s && (deb_cnt == DEB_LAST);
    assign sw_evt  = is_idle && sw_req;
    assign wdt_evt = is_idle && wdt_en && !wdt_kick && (wdt_cnt == WDT_LAST);
    // Button events are only accepted in IDLE; saturation stops a lost event re-firing.
    assign evts    = is_idle ? {wdt_evt, sw_evt, btn_evt} : 3'b000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s1  <= 1'b1;
            btn_s   <= 1'b1;
            deb_cnt <= '0;
        end else begin
            btn_s1 <= btn_n;
            btn_s  <= btn_s1;
            if (btn_s)
                deb_cnt <= '0;
            else if (deb_cnt != DEB_MAX)
                deb_cnt <= deb_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !wdt_en || wdt_kick || !is_idle || wdt_evt)
            wdt_cnt <= '0;
        else
            wdt_cnt <= wdt_cnt + WW'(1);
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (evts != 3'b000) begin
                    next_state = ASSERT;
                    next_cnt   = PULSE_LAST;
                end
            end
            ASSERT: begin
                if (cnt == '0) begin
                    next_state = HOLDOFF;
                    next_cnt   = HOLD_LAST;
                end else begin
                    next_cnt = cnt - CW'(1);
                end
            end
            HOLDOFF: begin
                if (cnt == '0)
                    next_state = IDLE;
                else
                    next_cnt = cnt - CW'(1);
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ASSERT;
            cnt       <= PULSE_LAST;
            rst_req_n <= 1'b0;
            busy      <= 1'b1;
            cause     <= 3'b000;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            rst_req_n <= (next_state != ASSERT);
            busy      <= (next_state != IDLE);
            cause     <= (cause_clr ? 3'b000 : cause) | evts;
        end
    end

endmodule

// File: doc/reset_req_gen.md
Name: reset_req_gen

Overview:
- Reset-request initiator for the 6502 system: gathers reset sources, qualifies them, and emits a clean, minimum-width active-low reset request `rst_req_n`.
- `rst_req_n` drives the asynchronous reset input of the downstream reset synchronizers.
- Reset sources:
  - debounced external button;
  - software request pulse;
  - watchdog timeout.
- Latches the reset cause for firmware readback.

Parameters:
- DEBOUNCE_CNT, 8: consecutive synchronized-low cycles of `btn_n` needed to qualify a button press (≥2).
- PULSE_LEN, 16: cycles `rst_req_n` is held low per request (≥1).
- HOLDOFF_LEN, 8: cycles after release during which new events are ignored (≥1).
- WDT_LIMIT, 1024: un-kicked enabled cycles before a watchdog event (≥2).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, synchronous, active-low.
- btn_n, input, 1: raw asynchronous button, active-low.
- sw_req, input, 1: software reset request, single-cycle pulse, synchronous to clk.
- wdt_en, input, 1: watchdog enable.
- wdt_kick, input, 1: watchdog service pulse.
- cause_clr, input, 1: clear all cause bits.
- rst_req_n, output, 1: registered reset request, active-low.
- busy, output, 1: FSM not in IDLE.
- cause, output, 3: sticky cause bits {wdt, sw, btn}.

Behaviour:
- Reset is synchronous: `rst_n` sampled low at a posedge sets:
  - state=ASSERT, cnt=PULSE_LEN-1;
  - rst_req_n=0, busy=1, cause=3'b000;
  - both btn sync flops=1, deb_cnt=0, wdt_cnt=0.
- Power-on pulse: after `rst_n` rises, `rst_req_n` stays low exactly PULSE_LEN cycles, then HOLDOFF, then IDLE.
- Button path:
  - 2-flop synchronizer produces `btn_s`.
  - `btn_s`=1 clears deb_cnt.
  - `btn_s`=0 increments deb_cnt, saturating at DEBOUNCE_CNT.
  - `btn_evt` = `btn_s`==0 && deb_cnt==DEBOUNCE_CNT-1. It fires once per press; a new event needs `btn_s` to return high.
  - The debounce counter runs in every FSM state. An event that occurs outside IDLE is lost (saturation prevents re-fire).
- Watchdog path:
  - wdt_cnt is cleared when any of the following holds: `wdt_en`=0, `wdt_kick`=1, state≠IDLE.
  - Otherwise wdt_cnt increments.
  - `wdt_evt` = IDLE && wdt_en && !wdt_kick && wdt_cnt==WDT_LIMIT-1; wdt_cnt then clears.
  - A kick in the same cycle as the limit wins (no event).
- Software path: `sw_evt` = `sw_req` sampled in IDLE.
- FSM (3 states):
  - IDLE: if any event, go to ASSERT with cnt=PULSE_LEN-1, and OR every simultaneous event into `cause`.
  - ASSERT: if cnt==0, go to HOLDOFF with cnt=HOLDOFF_LEN-1; else decrement cnt. Events are ignored and not latched.
  - HOLDOFF: if cnt==0, go to IDLE; else decrement cnt. Events are ignored.
- `rst_req_n` is a register loaded with (next_state != ASSERT):
  - it falls on the same edge that enters ASSERT;
  - every low pulse is exactly PULSE_LEN cycles;
  - no glitches.
- `busy` is a register loaded with (next_state != IDLE).
- `cause`:
  - sticky; persists across the requested reset (this block is not reset by its own request);
  - cleared only by `rst_n` or `cause_clr`;
  - if `cause_clr` and a new event coincide, the new event's bit ends set.
- Counter widths: $clog2 of the respective max value plus 1 as needed; no wrap is possible.
- Reset mid-operation (any state): returns to the full power-on sequence and clears `cause`.

Test Plan:
- Power-on: hold rst_n=0 for 3 cycles, then release. Required: rst_req_n=0 during reset and for 16 cycles after; busy=1 for 16+8 cycles, then 0; cause=000.
- Button: in IDLE, drive btn_n low and hold. Required: rst_req_n falls at the 10th posedge after btn_n is first sampled low; low 16 cycles; cause=001; holding btn_n low afterward gives no second pulse.
- Glitch rejection: btn_n low for 5 cycles, then high. Required: no pulse; cause unchanged.
- Software and simultaneous events: sw_req pulse in IDLE gives a 16-cycle pulse and cause=010. sw_req in the same cycle as btn_evt gives one pulse with cause=011. sw_req during ASSERT or HOLDOFF is ignored.
- Watchdog with WDT_LIMIT=16: wdt_en=1 with a kick every 10 cycles gives no reset. After the last kick, wdt_evt occurs on the 16th cycle and cause bit2 is set. Kicking on the limit cycle gives no event.
- cause_clr: cause_clr=1 gives cause=000 on the next cycle. cause_clr coincident with sw_evt gives cause=010. rst_n low during ASSERT restarts the full 16-cycle pulse with cause=000.
